// File: rtl/ysyx_22041412_mdu_pkg.sv
// Shared constants and types for the RV64M multiply/divide unit.
// The optional abort input is enabled with YSYX_22041412_MDU_FLUSH_EN.
package ysyx_22041412_mdu_pkg;

    localparam int XLEN = 64;
    localparam int WCYC = 32;
    localparam int CW   = 7;

    localparam logic [6:0] FUNC7_M = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return {{(XLEN-32){1'b0}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22041412_mdu_if.sv
// Request/response bundle between EXU (master) and the MDU (slave).
// Both directions use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both high; the sender holds its payload stable
// while valid is high and ready is low.
interface ysyx_22041412_mdu_if;
    import ysyx_22041412_mdu_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [2:0]      func3;
    logic            is_word;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport slave (
        input  in_valid, src1, src2, func3, is_word, out_ready,
        output in_ready, out_valid, result, busy
    );

    modport master (
        output in_valid, src1, src2, func3, is_word, out_ready,
        input  in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/ysyx_22041412_mdu_div.sv
// Restoring divider on unsigned magnitudes, one quotient bit per cycle.
// Word operations run WCYC iterations with the dividend pre-aligned to the
// top of the shift register; done is high during the final iteration and
// quotient/remainder then carry the finished values.
module ysyx_22041412_mdu_div
    import ysyx_22041412_mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            word,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic            running;
    logic            word_q;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dsr_q;
    logic [XLEN:0]   shifted;
    logic            ge;

    // One restoring step: shift in the next dividend bit and subtract if it fits.
    always_comb begin
        shifted   = {rem_q, quo_q[XLEN-1]};
        ge        = (shifted >= {1'b0, dsr_q});
        remainder = ge ? XLEN'(shifted - {1'b0, dsr_q}) : shifted[XLEN-1:0];
        quotient  = {quo_q[XLEN-2:0], ge};
        done      = running && (cnt == (word_q ? CW'(WCYC-1) : CW'(XLEN-1)));
    end

    // Load on start, then iterate until the last step has been taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            word_q  <= 1'b0;
            cnt     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
        end else if (start) begin
            running <= 1'b1;
            word_q  <= word;
            cnt     <= '0;
            rem_q   <= '0;
            quo_q   <= word ? (dividend << (XLEN-WCYC)) : dividend;
            dsr_q   <= divisor;
        end else if (running) begin
            rem_q <= remainder;
            quo_q <= quotient;
            cnt   <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ysyx_22041412_mdu.sv
// RV64M multiply/divide unit: shift-add multiplier and restoring divider,
// one operation in flight. Signed operations work on magnitudes and fix the
// sign when the result is captured. Divide-by-zero, signed overflow and
// illegal word encodings skip the iterative phase.
// Defining YSYX_22041412_MDU_FLUSH_EN adds a flush input that aborts work.
module ysyx_22041412_mdu
    import ysyx_22041412_mdu_pkg::*;
(
    input  logic clk,
    input  logic rst,
`ifdef YSYX_22041412_MDU_FLUSH_EN
    input  logic flush,
`endif
    ysyx_22041412_mdu_if.slave bus,
    output state_t dbg_state
);

    state_t state, state_n;
    logic              accept, calc_last, abort, special, div_start;
    logic              sgn1, sgn2, is_div, illegal, div0, ovf, a_neg, b_neg, neg_n;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, special_res;
    logic [2:0]        f3_q;
    logic              word_q, neg_q;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, mcand, acc_n, prod_s;
    logic [XLEN-1:0]   mplier, result_q, mul_res, div_val, div_s, div_res, calc_res;
    logic              div_done;
    logic [XLEN-1:0]   div_q, div_r;

`ifdef YSYX_22041412_MDU_FLUSH_EN
    assign abort = flush;
`else
    assign abort = 1'b0;
`endif

    // Operand preparation and the results of the cases that bypass iteration.
    always_comb begin
        is_div  = bus.func3[2];
        sgn1    = (bus.func3 != F3_MULHU) && (bus.func3 != F3_DIVU) && (bus.func3 != F3_REMU);
        sgn2    = sgn1 && (bus.func3 != F3_MULHSU);
        a_ext   = bus.is_word ? (sgn1 ? sext32(bus.src1[31:0]) : zext32(bus.src1[31:0])) : bus.src1;
        b_ext   = bus.is_word ? (sgn2 ? sext32(bus.src2[31:0]) : zext32(bus.src2[31:0])) : bus.src2;
        a_neg   = sgn1 && a_ext[XLEN-1];
        b_neg   = sgn2 && b_ext[XLEN-1];
        a_mag   = a_neg ? -a_ext : a_ext;
        b_mag   = b_neg ? -b_ext : b_ext;
        neg_n   = (is_div && bus.func3[1]) ? a_neg : (a_neg ^ b_neg);
        illegal = bus.is_word && !is_div && (bus.func3 != F3_MUL);
        div0    = is_div && (b_ext == '0);
        ovf     = is_div && sgn1 && (b_ext == '1) &&
                  (a_ext == (bus.is_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}}));
        special = illegal || div0 || ovf;
        special_res = '0;
        if (div0) begin
            special_res = bus.func3[1] ? (bus.is_word ? sext32(bus.src1[31:0]) : bus.src1) : '1;
        end else if (ovf) begin
            special_res = bus.func3[1] ? '0 : a_ext;
        end
    end

    // Multiplier step and final sign/width correction for both datapaths.
    always_comb begin
        acc_n     = acc + (mplier[0] ? mcand : '0);
        prod_s    = neg_q ? -acc_n : acc_n;
        mul_res   = (f3_q == F3_MUL) ? (word_q ? sext32(prod_s[31:0]) : prod_s[XLEN-1:0])
                                     : prod_s[2*XLEN-1:XLEN];
        div_val   = f3_q[1] ? div_r : div_q;
        div_s     = neg_q ? -div_val : div_val;
        div_res   = word_q ? sext32(div_s[31:0]) : div_s;
        calc_res  = f3_q[2] ? div_res : mul_res;
        calc_last = f3_q[2] ? div_done : (cnt == (word_q ? CW'(WCYC-1) : CW'(XLEN-1)));
    end

    // Next-state logic: accept in IDLE, iterate in CALC, hold result in DONE.
    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        div_start = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid && !abort) begin
                    accept    = 1'b1;
                    div_start = is_div && !special;
                    state_n   = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (abort)          state_n = IDLE;
                else if (calc_last) state_n = DONE;
            end
            DONE: begin
                if (abort || bus.out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Latched request, multiplier accumulators and the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            f3_q     <= '0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            result_q <= '0;
        end else if (accept) begin
            f3_q   <= bus.func3;
            word_q <= bus.is_word;
            neg_q  <= neg_n;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{XLEN{1'b0}}, a_mag};
            mplier <= b_mag;
            if (special) result_q <= special_res;
        end else if (state == CALC) begin
            acc    <= acc_n;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (calc_last && !abort) result_q <= calc_res;
        end
    end

    ysyx_22041412_mdu_div u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .word      (bus.is_word),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.result    = result_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_ysyx_22041412_mdu.sv
// Directed bench for the multiply/divide unit: the driver pushes expected
// results and latencies into queues, an independent monitor pops and compares
// on every result handshake.
module tb_ysyx_22041412_mdu;
    import ysyx_22041412_mdu_pkg::*;

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     cyc;
    int     n_cmp;
    int     n_err;
    int     lat_act;
    logic   seen_valid;

    logic [63:0] exp_q[$];
    int          lat_q[$];
    int          acc_q[$];
    string       name_q[$];

    ysyx_22041412_mdu_if bus();

    ysyx_22041412_mdu dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver: present one request, record its acceptance cycle and expectation.
    task automatic issue(input string name, input logic [2:0] f3, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int lat);
        int g;
        g = 0;
        @(negedge clk);
        while (!bus.in_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_issue_timeout: in_ready=%b required 1", name, bus.in_ready);
            return;
        end
        bus.func3    = f3;
        bus.is_word  = w;
        bus.src1     = a;
        bus.src2     = b;
        bus.in_valid = 1'b1;
        exp_q.push_back(exp);
        lat_q.push_back(lat);
        acc_q.push_back(cyc);
        name_q.push_back(name);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: pending=%0d required 0", exp_q.size());
            exp_q.delete();
            lat_q.delete();
            acc_q.delete();
            name_q.delete();
        end
    endtask

    task automatic run(input string name, input logic [2:0] f3, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat);
        issue(name, f3, w, a, b, exp, lat);
        wait_drain();
    endtask

    // Monitor / scoreboard: latency from first out_valid, value at handshake.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (!seen_valid) begin
                seen_valid = 1'b1;
                lat_act = (acc_q.size() != 0) ? (cyc - acc_q[0]) : -1;
            end
            if (bus.out_ready) begin
                seen_valid = 1'b0;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: result=%h with no request pending", bus.result);
                end else begin
                    logic [63:0] e;
                    int          l;
                    string       nm;
                    e  = exp_q.pop_front();
                    l  = lat_q.pop_front();
                    nm = name_q.pop_front();
                    void'(acc_q.pop_front());
                    n_cmp++;
                    if (bus.result !== e) begin
                        n_err++;
                        $display("FAIL %s: result %h expected %h", nm, bus.result, e);
                    end
                    if (l >= 0) begin
                        n_cmp++;
                        if (lat_act != l) begin
                            n_err++;
                            $display("FAIL %s_latency: %0d cycles expected %0d", nm, lat_act, l);
                        end
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        cyc          = 0;
        n_cmp        = 0;
        n_err        = 0;
        lat_act      = 0;
        seen_valid   = 1'b0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.src1     = '0;
        bus.src2     = '0;
        bus.func3    = '0;
        bus.is_word  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready",  64'(bus.in_ready),  64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_result",    bus.result,         64'd0);
        check("reset_busy",      64'(bus.busy),      64'd0);
        check("reset_state",     64'(dbg_state),     64'(IDLE));

        // Doubleword multiplies
        run("mul_7_m3",     F3_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
        run("mulhu_ones",   F3_MULHU,  1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run("mulh_ones",    F3_MULH,   1'b0, '1, '1, 64'h0, 65);
        run("mulhsu_m1_2",  F3_MULHSU, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run("mul_big_lo",   F3_MUL,    1'b0, 64'h1_0000_0001, 64'h1_0000_0001, 64'h0000_0002_0000_0001, 65);
        run("mulhu_big_hi", F3_MULHU,  1'b0, 64'h1_0000_0001, 64'h1_0000_0001, 64'h1, 65);

        // Word multiplies
        run("mulw_wrap",    F3_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        run("mulw_garbage", F3_MUL, 1'b1, 64'hDEAD_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFB,
            64'hFFFF_FFFF_FFFF_FFF1, 33);

        // Doubleword divides
        run("div_m20_3",  F3_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65);
        run("rem_m20_3",  F3_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run("divu_100_7", F3_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        run("remu_max_10", F3_REMU, 1'b0, '1, 64'd10, 64'd5, 65);

        // Bypass cases
        run("divu_by_0",  F3_DIVU, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run("remu_5_by_0", F3_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1);
        run("div_ovf",    F3_DIV,  1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        run("divw_ovf",   F3_DIV,  1'b1, 64'h0000_0001_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, -1);
        run("remw_by_0",  F3_REM,  1'b1, 64'h0000_0001_8000_0005, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0005, 1);
        run("mulw_nonzero_before_illegal", F3_MUL, 1'b1, 64'd6, 64'd7, 64'd42, 33);
        run("illegal_mulhw", F3_MULH, 1'b1, 64'd6, 64'd7, 64'd0, 1);

        // Word divides
        run("divw_100_7",   F3_DIV,  1'b1, 64'd100, 64'd7, 64'd14, 33);
        run("remw_m100_7",  F3_REM,  1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        run("divuw_fffe_2", F3_DIVU, 1'b1, 64'hFFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33);
        run("divuw_ffff_1", F3_DIVU, 1'b1, 64'hAAAA_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33);

        // Requests while busy are ignored and latched operands stay put
        issue("divu_busy", F3_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        bus.func3    = F3_MUL;
        bus.is_word  = 1'b0;
        bus.src1     = 64'd3;
        bus.src2     = 64'd3;
        bus.in_valid = 1'b1;
        repeat (20) @(negedge clk);
        bus.in_valid = 1'b0;
        wait_drain();

        // Consumer stall in DONE
        bus.out_ready = 1'b0;
        issue("mul_stall", F3_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
        begin
            int g;
            g = 0;
            while (!bus.out_valid && g < 200) begin
                @(negedge clk);
                g++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
            check("stall_result",    bus.result,         64'hFFFF_FFFF_FFFF_FFEB);
            check("stall_in_ready",  64'(bus.in_ready),  64'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        wait_drain();

        // Reset in the middle of an iterative operation
        @(negedge clk);
        bus.func3    = F3_MUL;
        bus.is_word  = 1'b0;
        bus.src1     = 64'd9;
        bus.src2     = 64'd9;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("midcalc_busy",  64'(bus.busy),  64'd1);
        check("midcalc_state", 64'(dbg_state), 64'(CALC));
        rst = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_busy",      64'(bus.busy),      64'd0);
        rst = 1'b0;
        run("mulhu_after_rst", F3_MULHU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);

        // Quiet period so any spurious result would reach the monitor
        repeat (100) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
